// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller beside decode: scoreboard of in-flight destinations, forward selects,
// load-use stall and branch-flush sequencing. Selects and stall are combinational; flush_if is registered.
module pipeline_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int ZERO_REG  = 31,
  parameter int CNT_W     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             id_valid,
  input  logic [REG_AW-1:0]                id_rn,
  input  logic [REG_AW-1:0]                id_rm,
  input  logic                             id_rn_used,
  input  logic                             id_rm_used,
  input  logic [REG_AW-1:0]                id_rd,
  input  logic                             id_regwrite,
  input  logic                             id_is_load,
  input  logic                             br_taken,
  output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_a_sel,
  output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_b_sel,
  output logic                             stall,
  output logic                             flush_if,
  output logic [CNT_W-1:0]                 stall_cnt,
  output logic [CNT_W-1:0]                 flush_cnt
);

  localparam int SW = $clog2(FWD_DEPTH+1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                               state_q, state_d;
  logic [2:0]                           fcnt_q, fcnt_d;
  logic [CNT_W-1:0]                     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]                     flush_cnt_q, flush_cnt_d;

  logic [FWD_DEPTH-1:0]                 sb_v_q,  sb_v_d;
  logic [FWD_DEPTH-1:0][REG_AW-1:0]     sb_rd_q, sb_rd_d;
  logic [FWD_DEPTH-1:0]                 sb_wr_q, sb_wr_d;
  logic [FWD_DEPTH-1:0]                 sb_ld_q, sb_ld_d;

  logic [FWD_DEPTH-1:0]                 match_a, match_b;
  logic                                 haz_a, haz_b;
  logic                                 br_accept;

  always_comb begin
    for (int i = 0; i < FWD_DEPTH; i++) begin
      match_a[i] = sb_v_q[i] && sb_wr_q[i] && (sb_rd_q[i] == id_rn) && (id_rn != REG_AW'(ZERO_REG));
      match_b[i] = sb_v_q[i] && sb_wr_q[i] && (sb_rd_q[i] == id_rm) && (id_rm != REG_AW'(ZERO_REG));
    end
  end

  // Walk oldest to youngest so the youngest producer overwrites older ones.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    haz_a     = 1'b0;
    haz_b     = 1'b0;
    for (int i = FWD_DEPTH-1; i >= 0; i--) begin
      if (id_rn_used && match_a[i]) begin
        fwd_a_sel = SW'(i+1);
        haz_a     = sb_ld_q[i] && (i < LOAD_LAT);
      end
      if (id_rm_used && match_b[i]) begin
        fwd_b_sel = SW'(i+1);
        haz_b     = sb_ld_q[i] && (i < LOAD_LAT);
      end
    end
  end

  assign flush_if  = (state_q == FLUSH);
  assign stall     = id_valid && !flush_if && (haz_a || haz_b);
  assign br_accept = (state_q == RUN) && br_taken && id_valid && !stall;

  always_comb begin
    sb_v_d  = sb_v_q;
    sb_rd_d = sb_rd_q;
    sb_wr_d = sb_wr_q;
    sb_ld_d = sb_ld_q;
    for (int i = FWD_DEPTH-1; i > 0; i--) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
      sb_wr_d[i] = sb_wr_q[i-1];
      sb_ld_d[i] = sb_ld_q[i-1];
    end
    sb_v_d[0]  = id_valid && !stall && !flush_if;
    sb_rd_d[0] = id_rd;
    sb_wr_d[0] = id_regwrite;
    sb_ld_d[0] = id_is_load;
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    case (state_q)
      RUN: begin
        if (br_accept) begin
          state_d     = FLUSH;
          fcnt_d      = 3'(FLUSH_CYC-1);
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (fcnt_q == 3'd0) state_d = RUN;
        else                fcnt_d  = fcnt_q - 3'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      sb_v_q      <= '0;
      sb_rd_q     <= '0;
      sb_wr_q     <= '0;
      sb_ld_q     <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      sb_v_q      <= sb_v_d;
      sb_rd_q     <= sb_rd_d;
      sb_wr_q     <= sb_wr_d;
      sb_ld_q     <= sb_ld_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
